// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and defaults for the matrix result path
package matrix_pkg;

    localparam int MATRIX_MEM_WIDTH_DEFAULT   = 32;
    localparam int MATRIX_C_MEM_DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry register FIFO carrying a data word plus last tag
module stream_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       count
);

    // Entry 0 is always the head; entry 1 is the one waiting behind it.
    logic [WIDTH:0] entry0_q, entry0_d;
    logic [WIDTH:0] entry1_q, entry1_d;
    logic [1:0]     count_q, count_d;
    logic           do_pop;
    logic           do_push;

    // Shift-register update: a pop moves entry 1 forward, a push fills the first free slot.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = {push_last, push_data};
                end else begin
                    entry1_d = {push_last, push_data};
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    entry0_d = {push_last, push_data};
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = {push_last, push_data};
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers; reset leaves the FIFO empty with zeroed entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_data = entry0_q[WIDTH-1:0];
    assign head_last = entry0_q[WIDTH];
    assign count     = count_q;

endmodule

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - streams the C result memory out as a valid/ready word stream
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int MATRIX_C_MEM_DEPTH = MATRIX_C_MEM_DEPTH_DEFAULT,
    parameter int MATRIX_MEM_WIDTH   = MATRIX_MEM_WIDTH_DEFAULT
) (
    input  logic                                  data_clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(MATRIX_C_MEM_DEPTH)-1:0] rd_address_c,
    output logic                                  rd_en_c,
    input  logic [MATRIX_MEM_WIDTH-1:0]           read_data_c,
    output logic [MATRIX_MEM_WIDTH-1:0]           out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last
);

    localparam int             AW        = $clog2(MATRIX_C_MEM_DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(MATRIX_C_MEM_DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   issue_cnt_q, issue_cnt_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [1:0]      fifo_count;
    logic            pop;
    logic            credit_ok;
    logic            pass_done;

    stream_fifo2 #(
        .WIDTH (MATRIX_MEM_WIDTH)
    ) u_fifo (
        .clk       (data_clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (read_data_c),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_data (out_data),
        .head_last (out_last),
        .count     (fifo_count)
    );

    // Credit check: words buffered plus the one returning, minus the one leaving, must leave room.
    always_comb begin
        pop       = out_valid && out_ready;
        credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        rd_en_c   = (state_q == STREAM) && credit_ok;
        pass_done = (state_q == DRAIN) && (fifo_count == 2'd0) && !inflight_q;
    end

    // Next-state logic for the pass FSM, issue counter and read-return tracking.
    always_comb begin
        state_d         = state_q;
        issue_cnt_d     = issue_cnt_q;
        inflight_d      = rd_en_c;
        inflight_last_d = rd_en_c && (issue_cnt_q == LAST_ADDR);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = STREAM;
                    issue_cnt_d = '0;
                end
            end
            STREAM: begin
                if (rd_en_c) begin
                    // Hold at the final address instead of wrapping; the pass is over.
                    if (issue_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pass_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any pass in progress.
    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign rd_address_c = issue_cnt_q;
    assign out_valid    = (fifo_count != 2'd0);
    assign busy         = (state_q != IDLE);
    assign done         = pass_done;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - self-checking bench for matrix_result_streamer
module tb_matrix_result_streamer;

    localparam int DEPTH   = 64;
    localparam int S_DEPTH = 4;

    logic        data_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  rd_address_c;
    logic        rd_en_c;
    logic [31:0] read_data_c;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic        s_start;
    logic        s_busy;
    logic        s_done;
    logic [1:0]  s_rd_address_c;
    logic        s_rd_en_c;
    logic [31:0] s_read_data_c;
    logic [31:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_out_last;

    logic [31:0] mem   [DEPTH];
    logic [31:0] mem_s [S_DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 data_clk = ~data_clk;
    always @(posedge data_clk) cyc <= cyc + 1;

    matrix_result_streamer #(
        .MATRIX_C_MEM_DEPTH (DEPTH),
        .MATRIX_MEM_WIDTH   (32)
    ) dut (
        .data_clk     (data_clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_address_c (rd_address_c),
        .rd_en_c      (rd_en_c),
        .read_data_c  (read_data_c),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    matrix_result_streamer #(
        .MATRIX_C_MEM_DEPTH (S_DEPTH),
        .MATRIX_MEM_WIDTH   (32)
    ) dut_small (
        .data_clk     (data_clk),
        .rst_n        (rst_n),
        .start        (s_start),
        .busy         (s_busy),
        .done         (s_done),
        .rd_address_c (s_rd_address_c),
        .rd_en_c      (s_rd_en_c),
        .read_data_c  (s_read_data_c),
        .out_data     (s_out_data),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .out_last     (s_out_last)
    );

    // One-cycle-latency memories behind both read ports
    always @(posedge data_clk) begin
        if (rd_en_c) read_data_c <= mem[rd_address_c];
        if (s_rd_en_c) s_read_data_c <= mem_s[s_rd_address_c];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumer readiness: 0 always ready, 1 toggling, 2 random, 3 held off
    int ready_mode = 0;
    always @(posedge data_clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: queue of words a pass must deliver, in order, tagged with last
    logic [32:0] exp_q[$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          outst = 0;
    int          last_xfer_cyc = -10;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;

    always @(negedge data_clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outst = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_word_held", 64'({out_last, out_data}), 64'(stall_word));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_expected", 64'd0, 64'd1);
                end else begin
                    check("xfer_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                end
                xfer_cnt++;
                outst--;
                last_xfer_cyc = cyc;
            end
            if (rd_en_c) begin
                rd_cnt++;
                outst++;
                check("outstanding_le2", 64'(outst <= 2), 64'd1);
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                check("done_after_last", 64'(cyc), 64'(last_xfer_cyc + 1));
            end
            stall_prev = out_valid && !out_ready;
            stall_word = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge data_clk);
        #1;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? $urandom : 32'h100 + 32'(i);
    endtask

    task automatic load_exp();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), mem[i]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        load_exp();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge data_clk);
            n++;
        end while (!done && n < budget);
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_xfers(input string tag, input int target, input int budget);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(negedge data_clk);
            n++;
        end
        check(tag, 64'(xfer_cnt >= target), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int x0, d0, r0, n, s_words, s_done_cnt, s_last_cyc, s_done_cyc;
        rst_n = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        s_out_ready = 1'b1;
        out_ready = 1'b0;
        fill_mem(1'b0);
        for (int i = 0; i < S_DEPTH; i++) mem_s[i] = 32'h200 + 32'(i);

        // 1: reset state, then a full pass with out_ready held high
        repeat (3) tick();
        @(negedge data_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_rd_en", 64'(rd_en_c), 64'd0);
        check("rst_rd_addr", 64'(rd_address_c), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        start = 1'b1;
        load_exp();
        @(negedge data_clk);
        check("t1_c0_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        @(negedge data_clk);
        check("t1_c1_rd_en", 64'(rd_en_c), 64'd1);
        check("t1_c1_addr", 64'(rd_address_c), 64'd0);
        check("t1_c1_busy", 64'(busy), 64'd1);
        @(negedge data_clk);
        check("t1_c2_valid", 64'(out_valid), 64'd0);
        @(negedge data_clk);
        check("t1_c3_valid", 64'(out_valid), 64'd1);
        check("t1_c3_data", 64'(out_data), 64'h100);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge data_clk);
            check("t1_valid_streak", 64'(out_valid), 64'd1);
        end
        @(negedge data_clk);
        check("t1_done_pulse", 64'(done), 64'd1);
        @(negedge data_clk);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_done_low", 64'(done), 64'd0);
        check("t1_xfers", 64'(xfer_cnt), 64'(DEPTH));
        check("t1_dones", 64'(done_cnt), 64'd1);

        // 2: toggling backpressure, then random backpressure, random data
        for (int m = 1; m <= 2; m++) begin
            tick();
            fill_mem(1'b1);
            ready_mode = m;
            x0 = xfer_cnt;
            pulse_start();
            wait_done("t2_done", 400);
            check("t2_xfers", 64'(xfer_cnt - x0), 64'(DEPTH));
        end

        // 3: consumer stalled for 20 cycles right after start
        tick();
        fill_mem(1'b0);
        ready_mode = 3;
        tick();
        r0 = rd_cnt;
        x0 = xfer_cnt;
        pulse_start();
        repeat (20) @(negedge data_clk);
        check("t3_rd_en_limit", 64'(rd_cnt - r0 <= 2), 64'd1);
        check("t3_valid_hold", 64'(out_valid), 64'd1);
        check("t3_data_hold", 64'(out_data), 64'h100);
        ready_mode = 0;
        wait_done("t3_done", 200);
        check("t3_xfers", 64'(xfer_cnt - x0), 64'(DEPTH));

        // 4: start during busy and in the done cycle is ignored; start after done begins a new pass
        tick();
        fill_mem(1'b1);
        ready_mode = 2;
        x0 = xfer_cnt;
        d0 = done_cnt;
        pulse_start();
        wait_xfers("t4_reach10", x0 + 10, 200);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4_done1", 400);
        start = 1'b1;
        check("t4_busy_in_done", 64'(busy), 64'd1);
        tick();
        load_exp();
        @(negedge data_clk);
        check("t4_idle_after_done", 64'(busy), 64'd0);
        check("t4_pass1_words", 64'(xfer_cnt - x0), 64'(DEPTH));
        check("t4_pass1_dones", 64'(done_cnt - d0), 64'd1);
        tick();
        start = 1'b0;
        @(negedge data_clk);
        check("t4_pass2_busy", 64'(busy), 64'd1);
        wait_done("t4_done2", 400);
        repeat (10) @(negedge data_clk);
        check("t4_total_words", 64'(xfer_cnt - x0), 64'(2 * DEPTH));
        check("t4_total_dones", 64'(done_cnt - d0), 64'd2);

        // 5: reset mid-stream abandons the pass; a fresh start streams from the beginning
        tick();
        fill_mem(1'b0);
        ready_mode = 0;
        x0 = xfer_cnt;
        pulse_start();
        wait_xfers("t5_reach10", x0 + 10, 100);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        d0 = done_cnt;
        @(negedge data_clk);
        check("t5_valid_after_rst", 64'(out_valid), 64'd0);
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        repeat (80) @(negedge data_clk);
        check("t5_no_done", 64'(done_cnt), 64'(d0));
        tick();
        x0 = xfer_cnt;
        pulse_start();
        wait_done("t5_done", 200);
        check("t5_xfers", 64'(xfer_cnt - x0), 64'(DEPTH));

        // 6: four-word memory with out_ready held high
        tick();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_words = 0;
        s_done_cnt = 0;
        s_last_cyc = -10;
        s_done_cyc = -20;
        n = 0;
        while (n < 15) begin
            @(negedge data_clk);
            n++;
            if (s_out_valid && s_out_ready) begin
                if (s_words < S_DEPTH) begin
                    check("t6_word", 64'(s_out_data), 64'(mem_s[s_words]));
                end
                check("t6_last", 64'(s_out_last), 64'(s_words == S_DEPTH - 1));
                s_words++;
                s_last_cyc = cyc;
            end
            if (s_done) begin
                s_done_cnt++;
                s_done_cyc = cyc;
            end
        end
        check("t6_word_count", 64'(s_words), 64'(S_DEPTH));
        check("t6_done_count", 64'(s_done_cnt), 64'd1);
        check("t6_done_timing", 64'(s_done_cyc), 64'(s_last_cyc + 1));
        check("t6_idle", 64'(s_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
